mux_nto1_pipe: RTL and testbench
================================

Name: mux_nto1_pipe

Overview:
- Parametrised successor to the 32-bit 4:1 operand mux.
- Selects one of NUM_INPUTS WIDTH-bit inputs and registers the result behind a 2-entry valid/ready skid buffer.
- Used at pipeline-stage boundaries (forwarding/operand select into EX, writeback-source select) where the consumer can stall.
- Provides in-order delivery, stall-safe acceptance, a flush, and an out-of-range select flag.

Parameters:
- WIDTH, 32, data width of each input and of out_data.
- NUM_INPUTS, 4, number of selectable inputs, minimum 2.
- SEL_W, $clog2(NUM_INPUTS), width of sel; must satisfy 2**SEL_W >= NUM_INPUTS.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH*NUM_INPUTS  packed inputs; input k occupies bits [k*WIDTH +: WIDTH], input 0 at the LSBs.
- sel  input  SEL_W  input index, sampled with data_in on an accepted transfer.
- in_valid  input  1  producer has data_in/sel valid.
- in_ready  output  1  block can accept this cycle.
- flush  input  1  discard all buffered entries.
- out_data  output  WIDTH  selected, registered data.
- out_sel_err  output  1  the entry at out_data was captured with sel >= NUM_INPUTS.
- out_valid  output  1  out_data/out_sel_err valid.
- out_ready  input  1  consumer takes the output this cycle.

Behaviour:
- Transfer rules:
  - Input transfer (in_fire) = in_valid & in_ready.
  - Output transfer (out_fire) = out_valid & out_ready.
- Selection: result = input[sel] when sel < NUM_INPUTS.
  - Otherwise result = input[NUM_INPUTS-1], with err = 1.
  - This matches the 4:1 default-to-last-input rule.
- Storage: main entry {main_data, main_err, main_v} drives the outputs directly; skid entry {skid_data, skid_err, skid_v}.
- in_ready = ~skid_v & ~reset. It depends only on registered state and reset; there is no combinational path from out_ready.
- States:
  - EMPTY: main_v=0, skid_v=0.
  - ONE: main_v=1, skid_v=0.
  - FULL: main_v=1, skid_v=1.
- Transitions (evaluated at each rising edge; flush and reset take priority):
  - EMPTY, in_fire -> ONE; main <= result.
  - EMPTY, no in_fire -> EMPTY.
  - ONE, in_fire & out_fire -> ONE; main <= result.
  - ONE, in_fire & ~out_fire -> FULL; skid <= result; main holds.
  - ONE, out_fire & ~in_fire -> EMPTY.
  - ONE, neither -> ONE; main holds.
  - FULL, out_fire -> ONE; main <= skid; skid_v <= 0. in_ready=0, so there is no in_fire.
  - FULL, ~out_fire -> FULL; all entries hold.
- Latency: 1 cycle from in_fire to out_valid when EMPTY.
- Throughput: 1 transfer/cycle while out_ready stays high.
- Order: strict FIFO. No entry is duplicated or dropped except by flush/reset.
- Output stability: while out_valid=1 & out_ready=0, out_data and out_sel_err must not change.
- flush:
  - Next state is EMPTY: main_v <= 0, skid_v <= 0.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed by the consumer.
  - Data registers may hold stale values.
- reset:
  - Next state is EMPTY.
  - out_valid=0, out_data=0, out_sel_err=0, skid_data=0, skid_err=0.
  - in_ready=0 while reset is high and 1 in the first cycle after reset.
  - Reset mid-transfer discards everything.
- Valid-only clearing: flush clears valid bits only; data is zeroed only by reset.

Test Plan:
- Reset, then NUM_INPUTS=4, inputs {0x11111111, 0x22222222, 0x33333333, 0x44444444}, sel=2, in_valid=1, out_ready=1 for 1 cycle -> next cycle out_valid=1, out_data=0x33333333, out_sel_err=0; after reset release, outputs were 0 and in_ready=1.
- Streaming: sel=0,1,2,3 on 4 consecutive cycles, out_ready=1 -> out_data 0x11111111, 0x22222222, 0x33333333, 0x44444444 on the 4 following cycles; in_ready stays 1 throughout.
- Backpressure: out_ready=0, send sel=0 then sel=1 -> in_ready=0 after the second accept and out_data holds 0x11111111; raise out_ready -> 0x11111111 then 0x22222222, after which in_ready returns to 1; no loss or duplication.
- Out-of-range select: NUM_INPUTS=6, WIDTH=16, inputs k=0..5 equal to 0x00A0+k, sel=7 -> out_data=0x00A5, out_sel_err=1; next entry with sel=3 -> 0x00A3, out_sel_err=0.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1; the item offered during flush never appears. Reset asserted mid-stream -> out_valid=0, out_data=0.
- Randomized in_valid/out_ready at 50% over 1000 items against a reference queue -> exact in-order match; out_data stable during every stall.

Source files
------------

// File: rtl/mux_nto1_pipe.sv
// N:1 operand select registered behind a 2-entry valid/ready skid buffer.
// Out-of-range selects fall back to the last input and raise out_sel_err.
module mux_nto1_pipe #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  parameter int SEL_W      = $clog2(NUM_INPUTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [WIDTH*NUM_INPUTS-1:0] data_in,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        flush,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_sel_err,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b11;

  logic [WIDTH-1:0] main_data;
  logic             main_err;
  logic             main_v;
  logic [WIDTH-1:0] skid_data;
  logic             skid_err;
  logic             skid_v;

  logic [WIDTH-1:0] result;
  logic             result_err;
  logic             in_fire;
  logic             out_fire;
  logic [1:0]       state;

  // Default to the last input; a matching index overrides it.
  always_comb begin
    result     = data_in[(NUM_INPUTS-1)*WIDTH +: WIDTH];
    result_err = 1'b1;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (sel == SEL_W'(k)) begin
        result     = data_in[k*WIDTH +: WIDTH];
        result_err = 1'b0;
      end
    end
  end

  assign in_ready    = ~skid_v & ~reset;
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = main_v & out_ready;
  assign state       = {skid_v, main_v};

  assign out_data    = main_data;
  assign out_sel_err = main_err;
  assign out_valid   = main_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      main_data <= '0;
      main_err  <= 1'b0;
      main_v    <= 1'b0;
      skid_data <= '0;
      skid_err  <= 1'b0;
      skid_v    <= 1'b0;
    end else if (flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data <= result;
            main_err  <= result_err;
            main_v    <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data <= result;
            main_err  <= result_err;
          end else if (in_fire) begin
            skid_data <= result;
            skid_err  <= result_err;
            skid_v    <= 1'b1;
          end else if (out_fire) begin
            main_v <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data <= skid_data;
            main_err  <= skid_err;
            skid_v    <= 1'b0;
          end
        end
        default: begin
          main_v <= 1'b0;
          skid_v <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// Bench for mux_nto1_pipe: directed vectors on 4x32 and 6x16 instances,
// then random traffic against a queue reference.
module tb_mux_nto1_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [127:0] a_data = '0;
  logic [1:0]   a_sel = '0;
  logic         a_iv = 1'b0;
  logic         a_ir;
  logic         a_flush = 1'b0;
  logic [31:0]  a_out;
  logic         a_err;
  logic         a_ov;
  logic         a_or = 1'b0;

  logic [95:0]  b_data = '0;
  logic [2:0]   b_sel = '0;
  logic         b_iv = 1'b0;
  logic         b_ir;
  logic         b_flush = 1'b0;
  logic [15:0]  b_out;
  logic         b_err;
  logic         b_ov;
  logic         b_or = 1'b0;

  mux_nto1_pipe #(.WIDTH(32), .NUM_INPUTS(4)) dut_a (
    .clk(clk), .reset(reset), .data_in(a_data), .sel(a_sel),
    .in_valid(a_iv), .in_ready(a_ir), .flush(a_flush),
    .out_data(a_out), .out_sel_err(a_err), .out_valid(a_ov),
    .out_ready(a_or)
  );

  mux_nto1_pipe #(.WIDTH(16), .NUM_INPUTS(6)) dut_b (
    .clk(clk), .reset(reset), .data_in(b_data), .sel(b_sel),
    .in_valid(b_iv), .in_ready(b_ir), .flush(b_flush),
    .out_data(b_out), .out_sel_err(b_err), .out_valid(b_ov),
    .out_ready(b_or)
  );

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  sel;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];
  logic [15:0] w[6];
  logic [16:0] q[$];
  logic [16:0] held;
  logic        stalled;
  logic        fire_in;
  logic        fire_out;
  int          pushed;
  int          cycles;

  initial begin
    vecs[0] = '{3'd7, 16'h00A5, 1'b1};
    vecs[1] = '{3'd3, 16'h00A3, 1'b0};
    vecs[2] = '{3'd0, 16'h00A0, 1'b0};
    vecs[3] = '{3'd5, 16'h00A5, 1'b0};
    vecs[4] = '{3'd6, 16'h00A5, 1'b1};
    vecs[5] = '{3'd1, 16'h00A1, 1'b0};

    // reset
    step();
    step();
    chk("ready_in_reset", {31'd0, a_ir}, 32'd0);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, a_ir}, 32'd1);
    chk("rst_valid", {31'd0, a_ov}, 32'd0);
    chk("rst_data", a_out, 32'd0);
    chk("rst_err", {31'd0, a_err}, 32'd0);

    // single item, 1-cycle latency
    a_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    a_sel = 2'd2;
    a_iv = 1'b1;
    a_or = 1'b1;
    step();
    a_iv = 1'b0;
    chk("first_valid", {31'd0, a_ov}, 32'd1);
    chk("first_data", a_out, 32'h33333333);
    chk("first_err", {31'd0, a_err}, 32'd0);

    // streaming
    a_sel = 2'd0;
    a_iv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stream_data", a_out, 32'h11111111 * (i + 1));
      chk("stream_valid", {31'd0, a_ov}, 32'd1);
      chk("stream_ready", {31'd0, a_ir}, 32'd1);
      if (i < 3) a_sel = 2'(i + 1);
      else a_iv = 1'b0;
    end
    step();
    chk("stream_drained", {31'd0, a_ov}, 32'd0);

    // backpressure
    a_or = 1'b0;
    a_iv = 1'b1;
    a_sel = 2'd0;
    step();
    a_sel = 2'd1;
    step();
    a_iv = 1'b0;
    chk("bp_ready_low", {31'd0, a_ir}, 32'd0);
    chk("bp_hold0", a_out, 32'h11111111);
    step();
    chk("bp_hold1", a_out, 32'h11111111);
    chk("bp_hold_valid", {31'd0, a_ov}, 32'd1);
    a_or = 1'b1;
    step();
    chk("bp_second", a_out, 32'h22222222);
    chk("bp_second_valid", {31'd0, a_ov}, 32'd1);
    chk("bp_ready_back", {31'd0, a_ir}, 32'd1);
    step();
    chk("bp_drained", {31'd0, a_ov}, 32'd0);

    // flush while FULL, offered item discarded
    a_or = 1'b0;
    a_iv = 1'b1;
    a_sel = 2'd0;
    step();
    a_sel = 2'd1;
    step();
    a_sel = 2'd3;
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    a_iv = 1'b0;
    chk("flush_full_valid", {31'd0, a_ov}, 32'd0);
    chk("flush_full_ready", {31'd0, a_ir}, 32'd1);
    // flush while EMPTY with an accepted item: it must vanish
    a_iv = 1'b1;
    a_sel = 2'd2;
    a_flush = 1'b1;
    step();
    a_flush = 1'b0;
    a_iv = 1'b0;
    chk("flush_drop_valid", {31'd0, a_ov}, 32'd0);
    a_iv = 1'b1;
    a_sel = 2'd3;
    step();
    a_iv = 1'b0;
    chk("after_flush_data", a_out, 32'h44444444);
    a_or = 1'b1;
    step();
    chk("after_flush_drain", {31'd0, a_ov}, 32'd0);

    // reset mid-stream
    a_or = 1'b0;
    a_iv = 1'b1;
    a_sel = 2'd1;
    step();
    a_sel = 2'd2;
    step();
    a_iv = 1'b0;
    reset = 1'b1;
    step();
    chk("midrst_valid", {31'd0, a_ov}, 32'd0);
    chk("midrst_data", a_out, 32'd0);
    chk("midrst_err", {31'd0, a_err}, 32'd0);
    chk("midrst_ready", {31'd0, a_ir}, 32'd0);
    reset = 1'b0;
    #1;
    chk("midrst_ready_back", {31'd0, a_ir}, 32'd1);
    step();

    // table vectors on the 6-input instance
    for (int k = 0; k < 6; k++) b_data[k*16 +: 16] = 16'h00A0 + 16'(k);
    b_or = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b_sel = vecs[i].sel;
      b_iv = 1'b1;
      step();
      chk("vec_data", {16'd0, b_out}, {16'd0, vecs[i].exp_data});
      chk("vec_err", {31'd0, b_err}, {31'd0, vecs[i].exp_err});
      chk("vec_valid", {31'd0, b_ov}, 32'd1);
    end
    b_iv = 1'b0;
    step();
    chk("vec_drained", {31'd0, b_ov}, 32'd0);

    // random traffic against a reference queue
    pushed = 0;
    cycles = 0;
    stalled = 1'b0;
    held = '0;
    while ((pushed < 1000 || q.size() != 0) && cycles < 20000) begin
      chk("rnd_valid", {31'd0, b_ov}, {31'd0, q.size() != 0});
      chk("rnd_ready", {31'd0, b_ir}, {31'd0, q.size() < 2});
      if (stalled) chk("rnd_stable", {15'd0, b_err, b_out}, {15'd0, held});
      for (int k = 0; k < 6; k++) begin
        w[k] = 16'($urandom);
        b_data[k*16 +: 16] = w[k];
      end
      b_sel = 3'($urandom_range(0, 7));
      b_iv = (pushed < 1000) ? 1'($urandom) : 1'b0;
      b_or = 1'($urandom);
      fire_in = b_iv & b_ir;
      fire_out = b_ov & b_or;
      if (fire_out) begin
        chk("rnd_order", {15'd0, b_err, b_out},
            {15'd0, (q.size() != 0) ? q[0] : 17'h1FFFF});
        if (q.size() != 0) void'(q.pop_front());
      end
      if (fire_in) begin
        if (b_sel < 6) q.push_back({1'b0, w[b_sel]});
        else q.push_back({1'b1, w[5]});
        pushed++;
      end
      stalled = b_ov & ~b_or;
      held = {b_err, b_out};
      step();
      cycles++;
    end
    chk("rnd_no_timeout", {31'd0, cycles < 20000}, 32'd1);
    chk("rnd_count", pushed, 1000);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
